// File: rtl/tdm_pkg.sv
// Shared constants, state type and helpers
// for the 4-slot TDM demultiplexer.
package tdm_pkg;

  localparam int NCH    = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int ch_off(
    input int ch,
    input int w
  );
    return ch * w;
  endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// Stream-in / channels-out bundle
// for the TDM demultiplexer.
interface tdm_demux4_if
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic                    din_valid;
  logic [WIDTH-1:0]        din;
  logic                    frame_sync;
  logic [NCH*WIDTH-1:0]    dout;
  logic [NCH-1:0]          ch_upd;
  logic                    frame_valid;
  logic                    sync_err;
  logic                    locked;
  logic [SLOT_W-1:0]       slot;

  modport master (
    output din_valid,
    output din,
    output frame_sync,
    input  dout,
    input  ch_upd,
    input  frame_valid,
    input  sync_err,
    input  locked,
    input  slot
  );

  modport slave (
    input  din_valid,
    input  din,
    input  frame_sync,
    output dout,
    output ch_upd,
    output frame_valid,
    output sync_err,
    output locked,
    output slot
  );

endinterface

// File: rtl/tdm_demux4_demux1to4.sv
// 2-bit select plus enable to one-hot
// write enable; inverse of the 4:1 mux.
module demux1to4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  // one-hot decode, all-zero when disabled
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: slot FSM,
// channel registers and pulse flags.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic         clk,
  input logic         rst_n,
  tdm_demux4_if.slave bus
);

  state_t               state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [NCH*WIDTH-1:0] dout_q, dout_d;
  logic [NCH-1:0]       ch_upd_q, ch_upd_d;
  logic                 fv_q, fv_d;
  logic                 serr_q, serr_d;
  logic                 wr_en;
  logic [SLOT_W-1:0]    wr_sel;
  logic [NCH-1:0]       we;

  // slot FSM: decide write target, next slot and flags
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    wr_en   = 1'b0;
    wr_sel  = '0;
    fv_d    = 1'b0;
    serr_d  = 1'b0;
    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            wr_en   = 1'b1;
            slot_d  = 2'd1;
            state_d = RUN;
          end
        end
        RUN: begin
          unique case (1'b1)
            (slot_q == 2'd0) && bus.frame_sync: begin
              wr_en  = 1'b1;
              slot_d = 2'd1;
            end
            (slot_q != 2'd0) && !bus.frame_sync: begin
              wr_en  = 1'b1;
              wr_sel = slot_q;
              slot_d = slot_q + 2'd1;
              fv_d   = (slot_q == 2'd3);
            end
            (slot_q != 2'd0) && bus.frame_sync: begin
              serr_d = 1'b1;
              wr_en  = 1'b1;
              slot_d = 2'd1;
            end
            default: begin
              serr_d  = 1'b1;
              slot_d  = 2'd0;
              state_d = HUNT;
            end
          endcase
        end
        default: state_d = HUNT;
      endcase
    end
  end

  demux1to4 u_dmx (
    .en  (wr_en),
    .sel (wr_sel),
    .y   (we)
  );

  // steer the word into the enabled channel slice
  always_comb begin
    dout_d   = dout_q;
    ch_upd_d = we;
    for (int i = 0; i < NCH; i++) begin
      if (we[i]) dout_d[ch_off(i, WIDTH) +: WIDTH] = bus.din;
    end
  end

  // state, channel and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      dout_q   <= '0;
      ch_upd_q <= '0;
      fv_q     <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      dout_q   <= dout_d;
      ch_upd_q <= ch_upd_d;
      fv_q     <= fv_d;
      serr_q   <= serr_d;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.ch_upd      = ch_upd_q;
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = serr_q;
  assign bus.locked      = (state_q == RUN);
  assign bus.slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Table, random and reset checks for
// the 4-slot TDM demultiplexer.
module tb_tdm_demux4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  tdm_demux4_if #(.WIDTH(1)) bus ();

  tdm_demux4 #(.WIDTH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       s;
    logic       d;
    logic [3:0] e_dout;
    logic [3:0] e_upd;
    logic       e_fv;
    logic       e_err;
    logic       e_lk;
    logic [1:0] e_slot;
  } vec_t;

  vec_t tbl[$];

  logic m_ch[4];
  logic m_locked;
  int   m_slot;
  int   m_run;
  logic [3:0] m_upd;
  logic m_fv;
  logic m_err;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h",
               nm, $time, act, exp);
    end
  endtask

  task automatic chk_all(input logic [3:0] dv,
                         input logic [3:0] up,
                         input logic fv,
                         input logic er,
                         input logic lk,
                         input logic [1:0] sl);
    chk("dout", 32'(bus.dout), 32'(dv));
    chk("ch_upd", 32'(bus.ch_upd), 32'(up));
    chk("frame_valid", 32'(bus.frame_valid), 32'(fv));
    chk("sync_err", 32'(bus.sync_err), 32'(er));
    chk("locked", 32'(bus.locked), 32'(lk));
    chk("slot", 32'(bus.slot), 32'(sl));
  endtask

  task automatic drive(input logic v,
                       input logic s,
                       input logic d);
    bus.din_valid  = v;
    bus.frame_sync = s;
    bus.din        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_ch[i] = 1'b0;
    m_locked = 1'b0;
    m_slot   = 0;
    m_run    = 0;
    m_upd    = '0;
    m_fv     = 1'b0;
    m_err    = 1'b0;
  endtask

  // frame-level model: a frame is good when four
  // consecutive slot writes follow one sync
  task automatic m_step(input logic v,
                        input logic s,
                        input logic d);
    m_upd = '0;
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_ch[0] = d; m_upd = 4'b0001;
          m_slot = 1; m_run = 1; m_locked = 1'b1;
        end
      end else if (s) begin
        m_err = (m_slot != 0);
        m_ch[0] = d; m_upd = 4'b0001;
        m_slot = 1; m_run = 1;
      end else if (m_slot == 0) begin
        m_err = 1'b1;
        m_locked = 1'b0;
        m_run = 0;
      end else begin
        m_ch[m_slot] = d;
        m_upd = 4'(1 << m_slot);
        m_run++;
        m_fv = (m_slot == 3) && (m_run == 4);
        m_slot = (m_slot + 1) % 4;
      end
    end
  endtask

  task automatic m_check();
    chk_all({m_ch[3], m_ch[2], m_ch[1], m_ch[0]},
            m_upd, m_fv, m_err, m_locked, 2'(m_slot));
  endtask

  task automatic add(input logic v, input logic s,
                     input logic d, input logic [3:0] dv,
                     input logic [3:0] up, input logic fv,
                     input logic er, input logic lk,
                     input logic [1:0] sl);
    vec_t t;
    t.v = v; t.s = s; t.d = d;
    t.e_dout = dv; t.e_upd = up; t.e_fv = fv;
    t.e_err = er; t.e_lk = lk; t.e_slot = sl;
    tbl.push_back(t);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    bus.din        = 1'b0;
    rst_n = 1'b0;

    // hunt: unsynced beats discarded
    add(1,0,1, 4'b0000,4'b0000,0,0,0,2'd0);
    add(1,0,1, 4'b0000,4'b0000,0,0,0,2'd0);
    add(1,0,1, 4'b0000,4'b0000,0,0,0,2'd0);
    add(0,1,1, 4'b0000,4'b0000,0,0,0,2'd0);
    // frame 1: 1,0,1,0 back to back
    add(1,1,1, 4'b0001,4'b0001,0,0,1,2'd1);
    add(1,0,0, 4'b0001,4'b0010,0,0,1,2'd2);
    add(1,0,1, 4'b0101,4'b0100,0,0,1,2'd3);
    add(1,0,0, 4'b0101,4'b1000,1,0,1,2'd0);
    // frame 2: 1,1,0,0 with 2-cycle gaps
    add(1,1,1, 4'b0101,4'b0001,0,0,1,2'd1);
    add(0,0,0, 4'b0101,4'b0000,0,0,1,2'd1);
    add(0,1,1, 4'b0101,4'b0000,0,0,1,2'd1);
    add(1,0,1, 4'b0111,4'b0010,0,0,1,2'd2);
    add(0,0,0, 4'b0111,4'b0000,0,0,1,2'd2);
    add(0,0,1, 4'b0111,4'b0000,0,0,1,2'd2);
    add(1,0,0, 4'b0011,4'b0100,0,0,1,2'd3);
    add(0,0,0, 4'b0011,4'b0000,0,0,1,2'd3);
    add(0,1,0, 4'b0011,4'b0000,0,0,1,2'd3);
    add(1,0,0, 4'b0011,4'b1000,1,0,1,2'd0);
    // missing sync at slot 0
    add(1,0,1, 4'b0011,4'b0000,0,1,0,2'd0);
    add(1,0,1, 4'b0011,4'b0000,0,0,0,2'd0);
    // early sync on slot 3
    add(1,1,0, 4'b0010,4'b0001,0,0,1,2'd1);
    add(1,0,0, 4'b0000,4'b0010,0,0,1,2'd2);
    add(1,0,1, 4'b0100,4'b0100,0,0,1,2'd3);
    add(1,1,1, 4'b0101,4'b0001,0,1,1,2'd1);
    add(1,0,1, 4'b0111,4'b0010,0,0,1,2'd2);
    add(1,0,1, 4'b0111,4'b0100,0,0,1,2'd3);
    add(1,0,1, 4'b1111,4'b1000,1,0,1,2'd0);

    repeat (2) @(posedge clk);
    #1;
    chk_all(4'b0000, 4'b0000, 0, 0, 0, 2'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d);
      chk_all(tbl[i].e_dout, tbl[i].e_upd,
              tbl[i].e_fv, tbl[i].e_err,
              tbl[i].e_lk, tbl[i].e_slot);
    end

    // random stream against the frame model
    drive(0, 0, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_reset();
    for (int k = 0; k < 400; k++) begin
      logic v, s, d;
      v = ($urandom_range(0, 9) < 7);
      d = 1'($urandom);
      if ($urandom_range(0, 9) < 8)
        s = (m_slot == 0);
      else
        s = 1'($urandom);
      m_step(v, s, d);
      drive(v, s, d);
      m_check();
    end

    // reset mid-frame, then a fresh 0101 frame
    m_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_step(1, 1, 0); drive(1, 1, 0); m_check();
    m_step(1, 0, 1); drive(1, 0, 1); m_check();
    rst_n = 1'b0;
    #1;
    m_reset();
    m_check();
    @(negedge clk);
    rst_n = 1'b1;
    m_step(1, 1, 1); drive(1, 1, 1); m_check();
    m_step(1, 0, 0); drive(1, 0, 0); m_check();
    m_step(1, 0, 1); drive(1, 0, 1); m_check();
    m_step(1, 0, 0); drive(1, 0, 0);
    chk_all(4'b0101, 4'b1000, 1, 0, 1, 2'd0);
    m_step(0, 0, 0); drive(0, 0, 0); m_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
